pe2_wb_ctrl: RTL and testbench

Write-back controller on the output side of PE2. It accepts one butterfly result pair per beat (PE2_out3/PE2_out4) and generates the matching pair of coefficient-RAM write addresses for the current NTT/INTT stage. A small FIFO decouples the PE pipeline from RAM write back-pressure. The block counts the butterflies in a stage, drains the FIFO, and pulses done, so the stage sequencer can launch the next stage.

---
 rtl/pe2_wb_ctrl_if.sv | 27 ++
 rtl/pe2_wb_ctrl.sv | 110 +++++++++++
 tb/tb_pe2_wb_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pe2_wb_ctrl_if.sv
// Bus bundle for the PE2 write-back controller: result beats in, paired RAM writes out.
// A transfer happens on a rising edge where valid and ready are both high; the producer
// holds payload stable while valid is high and ready is low, and ready never waits on valid.
interface pe2_wb_ctrl_if #(
    parameter int ADDR_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [23:0]       PE2_out3;
    logic [23:0]       PE2_out4;
    logic              wr_en;
    logic              wr_ready;
    logic [ADDR_W:0]   wr_addr0;
    logic [ADDR_W:0]   wr_addr1;
    logic [23:0]       wr_data0;
    logic [23:0]       wr_data1;

    modport slave (
        input  in_valid, PE2_out3, PE2_out4, wr_ready,
        output in_ready, wr_en, wr_addr0, wr_addr1, wr_data0, wr_data1
    );

    modport master (
        output in_valid, PE2_out3, PE2_out4, wr_ready,
        input  in_ready, wr_en, wr_addr0, wr_addr1, wr_data0, wr_data1
    );
endinterface

// File: rtl/pe2_wb_ctrl.sv
// PE2 write-back controller: tags butterfly pairs with stage-dependent RAM addresses,
// buffers them in a small FIFO and reports stage completion to the sequencer.
module pe2_wb_ctrl #(
    parameter int ADDR_W     = 6,
    parameter int STG_W      = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sel_1,
    input  logic [STG_W-1:0] stage,
    pe2_wb_ctrl_if.slave     bus,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       state_dbg
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 2 * (ADDR_W + 1) + 48;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  ONE_CNT  = CNT_W'(1);
    localparam logic [PTR_W-1:0]  ONE_PTR  = PTR_W'(1);
    localparam logic [ADDR_W-1:0] ONE_J    = ADDR_W'(1);
    localparam logic [ADDR_W:0]   ONE_A    = (ADDR_W + 1)'(1);
    localparam logic [STG_W-1:0]  STG_MAX  = STG_W'(ADDR_W);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] j_q;
    logic [STG_W-1:0]  k_q;
    logic [ENT_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              push, pop, fifo_full, last_beat;
    logic [STG_W-1:0]  stage_sat, k_start;
    logic [ADDR_W:0]   j_ext, d_val, top, bot;
    logic [ENT_W-1:0]  head;

    // k is the log2 half-distance; NTT shrinks it stage by stage, INTT grows it.
    assign stage_sat = (stage > STG_MAX) ? STG_MAX : stage;
    assign k_start   = sel_1 ? stage_sat : (STG_MAX - stage_sat);

    // Insert a zero at bit k of j to get the top index; bottom is d above it.
    assign j_ext = {1'b0, j_q};
    assign d_val = ONE_A << k_q;
    assign top   = (((j_ext >> k_q) << k_q) << 1) | (j_ext & (d_val - ONE_A));
    assign bot   = top + d_val;

    assign fifo_full    = (count == FULL_CNT);
    assign bus.in_ready = (state_q == RUN) && !fifo_full;
    assign push         = bus.in_valid && bus.in_ready;
    assign bus.wr_en    = (count != '0);
    assign pop          = bus.wr_en && bus.wr_ready;
    assign last_beat    = (j_q == '1);
    assign head         = mem[rd_ptr];

    assign {bus.wr_addr0, bus.wr_addr1, bus.wr_data0, bus.wr_data1} = bus.wr_en ? head : '0;

    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign done      = (state_q == DONE);
    assign state_dbg = state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (push && last_beat) state_d = DRAIN;
            // Finish as soon as the last pop handshakes so done follows it by one cycle.
            DRAIN:   if ((count == '0) || ((count == ONE_CNT) && pop)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            j_q     <= '0;
            k_q     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && start) begin
                j_q <= '0;
                k_q <= k_start;
            end else if (push) begin
                j_q <= j_q + ONE_J;
            end
            if (push) wr_ptr <= wr_ptr + ONE_PTR;
            if (pop)  rd_ptr <= rd_ptr + ONE_PTR;
            case ({push, pop})
                2'b10:   count <= count + ONE_CNT;
                2'b01:   count <= count - ONE_CNT;
                default: count <= count;
            endcase
            if (bus.in_valid && !bus.in_ready) err <= 1'b1;
        end
    end

    // Storage needs no reset: entries are only visible while count marks them valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {top, bot, bus.PE2_out3, bus.PE2_out4};
    end
endmodule

// File: tb/tb_pe2_wb_ctrl.sv
// Directed bench for pe2_wb_ctrl: address table per stage, scoreboarded write stream,
// back-pressure, protocol-error and mid-stage reset sequences.
module tb_pe2_wb_ctrl;
    localparam int ADDR_W = 6;
    localparam int FIFO_DEPTH = 4;
    localparam int W = 2 * (ADDR_W + 1) + 48;

    logic       clk;
    logic       rst;
    logic       start;
    logic       sel_1;
    logic [2:0] stage;
    logic       busy, done, err;
    logic [1:0] state_dbg;

    pe2_wb_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    pe2_wb_ctrl #(.ADDR_W(ADDR_W), .STG_W(3), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .sel_1(sel_1), .stage(stage),
        .bus(bus), .busy(busy), .done(done), .err(err), .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sel;
        logic [2:0] stg;
        int         j;
        int         a0;
        int         a1;
    } vec_t;

    vec_t          vecs[10];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic [W-1:0]  exp_q[$];
    int            acc_j, n_wr, first_acc, first_wen, last_wr_cyc, done_cyc, done_cnt, stall_acc;
    logic          m_sel;
    logic [2:0]    m_stg;
    logic          hold_pending = 1'b0;
    logic [W-1:0]  prev_out;
    logic [6:0]    cap_a0[64];
    logic [6:0]    cap_a1[64];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Butterfly pair in arithmetic form: block of 2d words, offset j mod d inside it.
    function automatic logic [W-1:0] model_entry(input logic sel, input logic [2:0] stg, input int j);
        int s, k, d, t;
        s = (stg > 3'd6) ? 6 : int'(stg);
        k = sel ? s : 6 - s;
        d = 1 << k;
        t = 2 * d * (j / d) + (j % d);
        return {7'(t), 7'(t + d), 24'(j), 24'(j + 1000)};
    endfunction

    task automatic mon_step();
        logic [W-1:0] cur;
        logic [W-1:0] e;
        cur = {bus.wr_addr0, bus.wr_addr1, bus.wr_data0, bus.wr_data1};
        if (rst) begin
            if (hold_pending) chk("hold_stable", {bus.wr_en, cur}, {1'b1, prev_out});
            if (bus.in_valid && bus.in_ready) begin
                if (acc_j == 0) first_acc = cyc;
                exp_q.push_back(model_entry(m_sel, m_stg, acc_j));
                acc_j++;
            end
            if (bus.wr_en && first_wen < 0) first_wen = cyc;
            if (bus.wr_en && bus.wr_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_write actual=%0h expected=none", cur);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_entry", cur, e);
                end
                if (n_wr < 64) begin
                    cap_a0[n_wr] = bus.wr_addr0;
                    cap_a1[n_wr] = bus.wr_addr1;
                end
                n_wr++;
                last_wr_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_at_done", busy, 0);
            end
            hold_pending = bus.wr_en && !bus.wr_ready;
            prev_out = cur;
        end else begin
            hold_pending = 1'b0;
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
    task automatic cycle();
        @(negedge clk);
        mon_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_wr_en"}, bus.wr_en, 0);
        chk({tag, "_wr_addr0"}, bus.wr_addr0, 0);
        chk({tag, "_wr_addr1"}, bus.wr_addr1, 0);
        chk({tag, "_wr_data0"}, bus.wr_data0, 0);
        chk({tag, "_wr_data1"}, bus.wr_data1, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_state"}, state_dbg, 0);
    endtask

    task automatic run_stage(input logic sel, input logic [2:0] stg, input int stall_len,
                             input int inj_cyc, input int mid_start, input int abort_at);
        int bj, sc, t;
        exp_q.delete();
        acc_j = 0; n_wr = 0; first_acc = -1; first_wen = -1;
        last_wr_cyc = -1; done_cyc = -1; done_cnt = 0; stall_acc = 0;
        m_sel = sel; m_stg = stg;
        start = 1'b1; sel_1 = sel; stage = stg;
        cycle();
        start = 1'b0; sel_1 = ~sel; stage = 3'd5;
        chk("busy_in_run", busy, 1);
        bj = 0; sc = 0;
        while (bj < 64 && sc < 500 && !(abort_at >= 0 && bj == abort_at)) begin
            bus.wr_ready = (sc >= stall_len);
            start = (mid_start >= 0 && bj == mid_start);
            if (bus.in_ready) begin
                bus.in_valid = 1'b1;
                bus.PE2_out3 = 24'(bj);
                bus.PE2_out4 = 24'(bj + 1000);
                if (sc < stall_len) stall_acc++;
                bj++;
            end else if (sc == inj_cyc) begin
                bus.in_valid = 1'b1;
                bus.PE2_out3 = 24'hbad;
                bus.PE2_out4 = 24'hbad;
            end else begin
                bus.in_valid = 1'b0;
            end
            cycle();
            sc++;
        end
        bus.in_valid = 1'b0;
        start = 1'b0;
        bus.wr_ready = 1'b1;
        if (abort_at >= 0) return;
        chk("beats_sent", bj, 64);
        t = 0;
        while (done_cnt == 0 && t < 200) begin
            cycle();
            t++;
        end
        repeat (3) cycle();
        chk("done_pulses", done_cnt, 1);
        chk("done_after_last_wr", done_cyc, last_wr_cyc + 1);
        chk("write_count", n_wr, 64);
        chk("queue_drained", exp_q.size(), 0);
        chk("first_wr_latency", first_wen, first_acc + 1);
        chk("busy_after_done", busy, 0);
        if (stall_len > FIFO_DEPTH) chk("accepts_while_stalled", stall_acc, FIFO_DEPTH);
    endtask

    initial begin
        vecs[0] = '{1'b0, 3'd0,  0,   0,  64};
        vecs[1] = '{1'b0, 3'd0, 37,  37, 101};
        vecs[2] = '{1'b0, 3'd6,  5,  10,  11};
        vecs[3] = '{1'b0, 3'd6, 63, 126, 127};
        vecs[4] = '{1'b1, 3'd2,  5,   9,  13};
        vecs[5] = '{1'b0, 3'd7,  5,  10,  11};
        vecs[6] = '{1'b0, 3'd7, 63, 126, 127};
        vecs[7] = '{1'b0, 3'd3, 13,  21,  29};
        vecs[8] = '{1'b1, 3'd6,  5,   5,  69};
        vecs[9] = '{1'b1, 3'd0, 63, 126, 127};

        start = 1'b0; sel_1 = 1'b0; stage = 3'd0;
        bus.in_valid = 1'b0; bus.PE2_out3 = '0; bus.PE2_out4 = '0; bus.wr_ready = 1'b1;
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b1;
        cycle();

        for (int i = 0; i < 10; i++) begin
            run_stage(vecs[i].sel, vecs[i].stg, 0, -1, -1, -1);
            chk($sformatf("vec%0d_addr0", i), cap_a0[vecs[i].j], vecs[i].a0);
            chk($sformatf("vec%0d_addr1", i), cap_a1[vecs[i].j], vecs[i].a1);
        end
        chk("err_clean_runs", err, 0);

        run_stage(1'b0, 3'd0, 10, -1, -1, -1);
        chk("err_after_stall", err, 0);

        // Stalled INTT stage with a beat offered into a full FIFO and a stray start mid-run.
        run_stage(1'b1, 3'd3, 10, 6, 30, -1);
        chk("err_full_fifo", err, 1);

        rst = 1'b0;
        #1;
        check_reset("reset2");
        rst = 1'b1;
        cycle();

        bus.in_valid = 1'b1;
        bus.PE2_out3 = 24'h123;
        bus.PE2_out4 = 24'h456;
        cycle();
        bus.in_valid = 1'b0;
        chk("err_idle_valid", err, 1);
        chk("no_write_idle", bus.wr_en, 0);
        repeat (2) cycle();
        chk("no_write_idle_later", bus.wr_en, 0);
        chk("err_sticky", err, 1);

        run_stage(1'b0, 3'd6, 0, -1, -1, 20);
        #2 rst = 1'b0;
        #1;
        check_reset("reset_mid");
        @(posedge clk);
        #1 rst = 1'b1;
        cycle();
        run_stage(1'b0, 3'd6, 0, -1, -1, -1);
        chk("post_reset_addr0", cap_a0[5], 10);
        chk("post_reset_addr1", cap_a1[63], 127);
        chk("post_reset_err", err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
